msg_stream_player: RTL and testbench

//  Parametrised character-stream engine: a loadable message buffer is played out one

---
 rtl/msg_stream_player.sv | 122 ++++++++++++
 tb/tb_msg_stream_player.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/msg_stream_player.sv
// Message buffer played out one character per programmable tick, with loop/one-shot modes.
// Optional MSG_PAUSE_EN adds a pause input that freezes playback while in PLAY.
module msg_stream_player #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 32,
    parameter  int DIV_W  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     msg_last,
    input  logic [DIV_W-1:0]  div,
    input  logic              loop_mode,
    input  logic              start,
    input  logic              stop,
`ifdef MSG_PAUSE_EN
    input  logic              pause,
`endif
    output logic [DATA_W-1:0] char_out,
    output logic              char_valid,
    output logic              busy,
    output logic              done
);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     index, index_n, last_q, last_n;
    logic [DIV_W-1:0]  presc, presc_n, div_q, div_n;
    logic              loop_q, loop_n;
    logic [DATA_W-1:0] char_n;
    logic              valid_n, done_n;
    logic              paused;

`ifdef MSG_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    // Buffer is not reset; a same-edge write is invisible to the read below.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_comb begin
        state_n = state;
        index_n = index;
        presc_n = presc;
        last_n  = last_q;
        div_n   = div_q;
        loop_n  = loop_q;
        char_n  = char_out;
        valid_n = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_n = PLAY;
                    last_n  = msg_last;
                    div_n   = div;
                    loop_n  = loop_mode;
                    index_n = '0;
                    presc_n = '0;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (!paused) begin
                    if (presc == div_q) begin
                        char_n  = mem[index];
                        valid_n = 1'b1;
                        presc_n = '0;
                        if (index < last_q) begin
                            index_n = index + 1'b1;
                        end else if (loop_q) begin
                            index_n = '0;
                        end else begin
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end
                    end else begin
                        presc_n = presc + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            index      <= '0;
            presc      <= '0;
            last_q     <= '0;
            div_q      <= '0;
            loop_q     <= 1'b0;
            char_out   <= '0;
            char_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            index      <= index_n;
            presc      <= presc_n;
            last_q     <= last_n;
            div_q      <= div_n;
            loop_q     <= loop_n;
            char_out   <= char_n;
            char_valid <= valid_n;
            busy       <= (state_n == PLAY);
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_msg_stream_player.sv
// Directed self-checking bench for msg_stream_player; pause steps need MSG_PAUSE_EN.
module tb_msg_stream_player;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [4:0]  msg_last = '0;
    logic [15:0] div = '0;
    logic        loop_mode = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
`ifdef MSG_PAUSE_EN
    logic        pause = 1'b0;
`endif
    logic [7:0]  char_out;
    logic        char_valid;
    logic        busy;
    logic        done;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  exp_mem [32];
    logic [7:0]  exp_char = 8'h00;

    msg_stream_player #(.DATA_W(8), .DEPTH(32), .DIV_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .msg_last   (msg_last),
        .div        (div),
        .loop_mode  (loop_mode),
        .start      (start),
        .stop       (stop),
`ifdef MSG_PAUSE_EN
        .pause      (pause),
`endif
        .char_out   (char_out),
        .char_valid (char_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
        exp_mem[a] = d;
    endtask

    task automatic check_outs(input string tag, input logic v, input logic dn, input logic b);
        chk({tag, ".char_out"}, char_out, exp_char);
        chk({tag, ".char_valid"}, char_valid, v);
        chk({tag, ".done"}, done, dn);
        chk({tag, ".busy"}, busy, b);
    endtask

    // One-shot playback; poke>0 raises start just before edge number poke.
    task automatic run_oneshot(input string tag, input int dv, input int last, input int poke);
        int n;
        logic v;
        msg_last = 5'(last); div = 16'(dv); loop_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check_outs({tag, ".accept"}, 1'b0, 1'b0, 1'b1);
        n = (dv + 1) * (last + 1);
        for (int k = 1; k <= n; k++) begin
            if (k == poke) start = 1'b1;
            tick();
            start = 1'b0;
            v = ((k % (dv + 1)) == 0);
            if (v) exp_char = exp_mem[k / (dv + 1) - 1];
            check_outs(tag, v, (k == n), (k < n));
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0);
        #5 rst_n = 1'b1;

        wr(5'd0, 8'h48);
        wr(5'd1, 8'h4F);
        wr(5'd2, 8'h4C);
        wr(5'd3, 8'h41);

        run_oneshot("oneshot_div2", 2, 3, 0);
        tick();
        check_outs("after_done", 1'b0, 1'b0, 1'b0);

        msg_last = 5'd3; div = 16'd0; loop_mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_char = exp_mem[(k - 1) % 4];
            check_outs("loop_div0", 1'b1, 1'b0, 1'b1);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop.char_held", char_out, 8'h4F);
        check_outs("stop", 1'b0, 1'b0, 1'b0);

        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check_outs("start_stop_idle", 1'b0, 1'b0, 1'b0);

        run_oneshot("start_in_play", 2, 3, 4);

        run_oneshot("single_div5", 5, 0, 0);

        msg_last = 5'd3; div = 16'd0; loop_mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 2) begin
                wr_en = 1'b1; wr_addr = 5'd1; wr_data = 8'h5A;
            end
            tick();
            wr_en = 1'b0;
            exp_char = exp_mem[(k - 1) % 4];
            check_outs("write_hazard", 1'b1, 1'b0, 1'b1);
            if (k == 2) exp_mem[1] = 8'h5A;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_outs("hazard_stop", 1'b0, 1'b0, 1'b0);

        msg_last = 5'd3; div = 16'd1; loop_mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        exp_char = 8'h48;
        check_outs("pre_reset", 1'b1, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        exp_char = 8'h00;
        check_outs("async_reset", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_outs("post_reset", 1'b0, 1'b0, 1'b0);

`ifdef MSG_PAUSE_EN
        // Emissions normally at edges 2,4,6,8; pausing edges 3..6 moves the rest by 4.
        msg_last = 5'd3; div = 16'd1; loop_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            logic v;
            int idx;
            pause = (k >= 3 && k <= 6);
            tick();
            pause = 1'b0;
            v = (k == 2 || k == 8 || k == 10 || k == 12);
            idx = (k == 2) ? 0 : (k - 6) / 2;
            if (v) exp_char = exp_mem[idx];
            check_outs("pause", v, (k == 12), (k < 12));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
